// File: rtl/vga_scanout_if.sv
// Framebuffer read-port bundle between the scanout engine (master) and the
// pixel-clock BRAM port (slave). fb_data is valid one clock after fb_addr.
interface vga_scanout_if #(
  parameter int ADDR_W = 17
);
  logic [ADDR_W-1:0] fb_addr;
  logic [15:0]       fb_data;

  modport master (output fb_addr, input  fb_data);
  modport slave  (input  fb_addr, output fb_data);
endinterface

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA timing generator and QVGA framebuffer reader.
// Each 320x240 RGB444 framebuffer pixel is doubled in both directions.
// Pipeline: stage 0 counters, stage 1 address register, stage 2 BRAM read,
// stage 3 colour/sync registers, so counter->pin latency is 3 clocks.
// Optional feature macro: VGA_SCANOUT_TESTPAT_EN (8 vertical colour bars
// when test_pat=1). Without it test_pat is ignored.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FB_W     = 320,
  parameter int FB_H     = 240,
  parameter int ADDR_W   = $clog2(FB_W*FB_H)
) (
  input  logic          clk25,
  input  logic          rst,
  vga_scanout_if.master fb,
  output logic [3:0]    vga_r,
  output logic [3:0]    vga_g,
  output logic [3:0]    vga_b,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          frame_start,
  input  logic          test_pat
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // h is at least 10 bits so the bar index h[9:7] always exists
  localparam int HW = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
  localparam int VW = ($clog2(V_TOTAL) > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);

  // ---------------- stage 0: raster counters ----------------
  logic [HW-1:0]     h;
  logic [VW-1:0]     v;
  logic [ADDR_W-1:0] row_base;   // (v>>1)*FB_W, tracked without a multiplier
  logic              h_wrap, v_wrap;
  logic              de0, hs0, vs0;

  assign h_wrap = (h == H_LAST);
  assign v_wrap = (v == V_LAST);
  assign de0    = (h < H_ACT) && (v < V_ACT);
  assign hs0    = ~((h >= HS_BEG) && (h < HS_END));
  assign vs0    = ~((v >= VS_BEG) && (v < VS_END));

  // Gated by rst so the pulse cannot appear while the counters are held at 0;
  // the first clock after release is h=0,v=0 and pulses immediately.
  assign frame_start = ~rst & (h == '0) & (v == '0);

  // Raster position and framebuffer row base; row advances after every odd
  // active line so each framebuffer row is scanned twice.
  always_ff @(posedge clk25) begin
    if (rst) begin
      h        <= '0;
      v        <= '0;
      row_base <= '0;
    end else begin
      h <= h_wrap ? '0 : h + 1'b1;
      if (h_wrap) begin
        v <= v_wrap ? '0 : v + 1'b1;
        if (v_wrap)
          row_base <= '0;
        else if (v[0] && (v < V_ACT))
          row_base <= row_base + ROW_STEP;
      end
    end
  end

  // ---------------- stage 1: framebuffer address ----------------
  // Column h>>1 doubles pixels horizontally; address parks at 0 in blanking.
  always_ff @(posedge clk25) begin
    if (rst) fb.fb_addr <= '0;
    else     fb.fb_addr <= de0 ? (row_base + ADDR_W'(h[HW-1:1])) : '0;
  end

  // ---------------- stages 1..2: sideband delay ----------------
  logic [2:1] vld_pipe;   // delayed display-enable
  logic [2:1] hs_pipe;
  logic [2:1] vs_pipe;

  // Carry de/hs/vs alongside the BRAM read so they reach stage 3 with the data.
  always_ff @(posedge clk25) begin
    if (rst) begin
      vld_pipe <= '0;
      hs_pipe  <= '1;
      vs_pipe  <= '1;
    end else begin
      vld_pipe <= {vld_pipe[1], de0};
      hs_pipe  <= {hs_pipe[1],  hs0};
      vs_pipe  <= {vs_pipe[1],  vs0};
    end
  end

  // ---------------- stage 3: pixel selection ----------------
  logic [11:0] pix_nxt;
  logic [11:0] rgb;

`ifdef VGA_SCANOUT_TESTPAT_EN
  logic [2:1][2:0] bar_pipe;   // h[9:7] delayed to line up with stage 3
  logic            unused_ok;
  assign unused_ok = &{1'b0, fb.fb_data[15:12]};

  // Bar index follows the pixel through the pipe like de/hs/vs.
  always_ff @(posedge clk25) begin
    if (rst) bar_pipe <= '0;
    else     bar_pipe <= {bar_pipe[1], h[9:7]};
  end

  // Colour source: bars when test_pat is high, framebuffer otherwise; black
  // outside the active window in both cases.
  always_comb begin
    pix_nxt = '0;
    if (vld_pipe[2]) begin
      if (test_pat)
        pix_nxt = {{4{bar_pipe[2][2]}}, {4{bar_pipe[2][1]}}, {4{bar_pipe[2][0]}}};
      else
        pix_nxt = fb.fb_data[11:0];
    end
  end
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, test_pat, fb.fb_data[15:12]};

  // Framebuffer colour inside the active window, black elsewhere.
  always_comb begin
    pix_nxt = '0;
    if (vld_pipe[2]) pix_nxt = fb.fb_data[11:0];
  end
`endif

  // Output registers: colour and syncs leave together on the same edge.
  always_ff @(posedge clk25) begin
    if (rst) begin
      rgb    <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else begin
      rgb    <= pix_nxt;
      vga_hs <= hs_pipe[2];
      vga_vs <= vs_pipe[2];
    end
  end

  assign vga_r = rgb[11:8];
  assign vga_g = rgb[7:4];
  assign vga_b = rgb[3:0];
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a reduced-timing instance (full pixel model, table
// vectors, sync/blanking measurements) plus a default 640x480 instance for
// real sync offsets, addressing of the first lines and test-pattern bars.
module tb_vga_scanout;
  localparam int HA = 64, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;
  localparam int VA = 16, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
  localparam int FBW = 32, FBH = 8, AW = 8, FRAME = HT * VT;
  localparam int BHA = 640, BHT = 800, BVA = 480, BVT = 525, BFW = 320;
`ifdef VGA_SCANOUT_TESTPAT_EN
  localparam bit TPB = 1'b1;
`else
  localparam bit TPB = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, tp = 1'b0, tp_edge = 1'b0;
  always #5 clk = ~clk;

  vga_scanout_if #(.ADDR_W(AW)) fbs();
  vga_scanout_if                fbb();
  logic [3:0] sr, sg, sb, br, bg, bb;
  logic shs, svs, sfs, bhs, bvs, bfs;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FB_W(FBW), .FB_H(FBH), .ADDR_W(AW)
  ) u_small (
    .clk25(clk), .rst(rst), .fb(fbs.master),
    .vga_r(sr), .vga_g(sg), .vga_b(sb), .vga_hs(shs), .vga_vs(svs),
    .frame_start(sfs), .test_pat(tp)
  );

  vga_scanout u_big (
    .clk25(clk), .rst(rst), .fb(fbb.master),
    .vga_r(br), .vga_g(bg), .vga_b(bb), .vga_hs(bhs), .vga_vs(bvs),
    .frame_start(bfs), .test_pat(tp)
  );

  // BRAM models: one-clock read latency
  logic [15:0] mem [0:255];
  always @(posedge clk) fbs.fb_data <= mem[fbs.fb_addr];
  always @(posedge clk) fbb.fb_data <= {4'h0, fbb.fb_addr[11:0]};

  int total = 0, bad = 0;
  int tcnt = 0;   // clocks since reset release; counter position of stage 0

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0h want=%0h", nm, tcnt, act, exp);
    end
  endtask

  function automatic logic [11:0] bar(input int h);
    logic [9:0] hv;
    logic [2:0] idx;
    hv  = h[9:0];
    idx = hv[9:7];
    return {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}};
  endfunction

  // Reference: pins show the raster position of 3 clocks ago, fb_addr of 1.
  task automatic check_cycle();
    int p, h, v;
    logic [11:0] e_rgb;
    logic e_hs, e_vs;
    int e_addr;
    // reduced instance
    e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; e_addr = 0;
    if (!rst) begin
      if (tcnt >= 1) begin
        p = tcnt - 1; h = p % HT; v = (p / HT) % VT;
        if (h < HA && v < VA) e_addr = (v / 2) * FBW + h / 2;
      end
      if (tcnt >= 3) begin
        p = tcnt - 3; h = p % HT; v = (p / HT) % VT;
        if (h < HA && v < VA)
          e_rgb = (TPB && tp_edge) ? bar(h) : mem[(v / 2) * FBW + h / 2][11:0];
        e_hs = !(h >= HA + HF && h < HA + HF + HS);
        e_vs = !(v >= VA + VF && v < VA + VF + VS);
      end
    end
    chk("s_rgb", {sr, sg, sb}, e_rgb);
    chk("s_hs", shs, e_hs);
    chk("s_vs", svs, e_vs);
    chk("s_addr", fbs.fb_addr, e_addr);
    chk("s_fs", sfs, !rst && (tcnt % FRAME == 0));
    // full-size instance
    e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; e_addr = 0;
    if (!rst) begin
      if (tcnt >= 1) begin
        p = tcnt - 1; h = p % BHT; v = (p / BHT) % BVT;
        if (h < BHA && v < BVA) e_addr = (v / 2) * BFW + h / 2;
      end
      if (tcnt >= 3) begin
        p = tcnt - 3; h = p % BHT; v = (p / BHT) % BVT;
        if (h < BHA && v < BVA)
          e_rgb = (TPB && tp_edge) ? bar(h) : 12'((v / 2) * BFW + h / 2);
        e_hs = !(h >= 656 && h < 752);
        e_vs = !(v >= 490 && v < 492);
      end
    end
    chk("b_rgb", {br, bg, bb}, e_rgb);
    chk("b_hs", bhs, e_hs);
    chk("b_vs", bvs, e_vs);
    chk("b_addr", fbb.fb_addr, e_addr);
    chk("b_fs", bfs, !rst && (tcnt % (BHT * BVT) == 0));
  endtask

  task automatic tick();
    tp_edge = tp;
    @(posedge clk);
    if (rst) tcnt = 0; else tcnt++;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 256; i++)
      mem[i] = (mode == 0) ? 16'(i) : (mode == 1) ? 16'h0FFF :
               (mode == 2) ? 16'hF123 : 16'($urandom);
  endtask

  task automatic release_rst();
    rst = 1'b0;
    #1;
    chk("fs_release_s", sfs, 1'b1);
    chk("fs_release_b", bfs, 1'b1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    release_rst();
  endtask

  typedef struct {
    int mode; int h; int v; logic [11:0] rgb; int addr;
  } vec_t;
  vec_t vt [10];

  initial begin
    int fs1, fs2, hs_fall, hs_w, vs_w, nb, bhs_fall, bhs_w, target;
    logic prev_s, prev_b;

    vt[0] = '{0,  5,  0, 12'h002,   2};
    vt[1] = '{0,  5,  1, 12'h002,   2};
    vt[2] = '{0,  0,  2, 12'h020,  32};
    vt[3] = '{0, 63, 15, 12'h0FF, 255};
    vt[4] = '{0, 64,  0, 12'h000,   0};
    vt[5] = '{0, 10, 16, 12'h000,   0};
    vt[6] = '{1, 10,  3, 12'hFFF,  37};
    vt[7] = '{1, 70,  3, 12'h000,   0};
    vt[8] = '{2,  7,  7, 12'h123,  99};
    vt[9] = '{2, 79, 22, 12'h000,   0};

    fill(0);
    do_reset(3);

    // table vectors: one pixel position per record
    for (int i = 0; i < 10; i++) begin
      fill(vt[i].mode);
      do_reset(2);
      target = vt[i].v * HT + vt[i].h;
      while (tcnt < target + 1) tick();
      chk("vec_addr", fbs.fb_addr, vt[i].addr);
      while (tcnt < target + 3) tick();
      chk("vec_rgb", {sr, sg, sb}, vt[i].rgb);
    end

    // sync timing, blanking and frame period over two frames
    fill(1);
    do_reset(3);
    fs1 = -1; fs2 = -1; hs_fall = -1; hs_w = 0; vs_w = 0; nb = 0;
    bhs_fall = -1; bhs_w = 0; prev_s = 1'b1; prev_b = 1'b1;
    for (int n = 0; n < 2 * FRAME + 8; n++) begin
      tick();
      if (sfs) begin
        if (fs1 < 0) fs1 = tcnt; else if (fs2 < 0) fs2 = tcnt;
      end
      if (!shs && prev_s && hs_fall < 0) hs_fall = tcnt;
      if (!shs && tcnt < HT + 3) hs_w++;
      if (!bhs && prev_b && bhs_fall < 0) bhs_fall = tcnt;
      if (!bhs && tcnt < BHT + 3) bhs_w++;
      if (tcnt >= 3 && tcnt < FRAME + 3) begin
        if (!svs) vs_w++;
        if ({sr, sg, sb} != 12'h0) nb++;
      end
      prev_s = shs; prev_b = bhs;
    end
    chk("fs_first", fs1, FRAME);
    chk("fs_period", fs2 - fs1, FRAME);
    chk("hs_first_low", hs_fall, HA + HF + 3);
    chk("hs_width", hs_w, HS);
    chk("vs_width", vs_w, VS * HT);
    chk("nonblack", nb, HA * VA);
    chk("b_hs_first_low", bhs_fall, 659);
    chk("b_hs_width", bhs_w, 96);

`ifdef VGA_SCANOUT_TESTPAT_EN
    // colour bars on the full-size instance, then revert to framebuffer data
    do_reset(2);
    tp = 1'b1;
    while (tcnt < 100 + 3) tick();
    chk("bar_black", {br, bg, bb}, 12'h000);
    while (tcnt < 128 + 3) tick();
    chk("bar_blue", {br, bg, bb}, 12'h00F);
    while (tcnt < 512 + 3) tick();
    chk("bar_red", {br, bg, bb}, 12'hF00);
    tp = 1'b0;
    tick();
    chk("bar_revert", {br, bg, bb}, 12'h100);
`endif

    // random contents, random test_pat, resets dropped mid-frame
    for (int it = 0; it < 6; it++) begin
      int len;
      len = $urandom_range(2 * FRAME, 50);
      for (int n = 0; n < len; n++) begin
        if ($urandom_range(15, 0) == 0) tp = ~tp;
        tick();
      end
      rst = 1'b1;
      repeat (5) tick();
      chk("rst_rgb", {sr, sg, sb}, 12'h000);
      chk("rst_sync", {shs, svs, bhs, bvs}, 4'hF);
      chk("rst_addr", fbs.fb_addr, 0);
      fill(3);
      release_rst();
    end
    repeat (FRAME + 10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
